// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer with memory-wait FSM and timeout.
// Define PIPE_HAZARD_PERF_CNT_EN to add the stall_cycles/flush_events counters.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MEM_TIMEOUT = 15
`ifdef PIPE_HAZARD_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  PCSrc_in_Mem,
  input  logic                  MemRead_in_Ex,
  input  logic [REG_ADDR_W-1:0] rd_in_Ex,
  input  logic [REG_ADDR_W-1:0] rs1_in_ID,
  input  logic [REG_ADDR_W-1:0] rs2_in_ID,
  input  logic                  rs1_used_ID,
  input  logic                  rs2_used_ID,
  input  logic                  mem_req,
  input  logic                  mem_ack,
  output logic                  PC_en,
  output logic                  IF_ID_en,
  output logic                  ID_EX_en,
  output logic                  EX_MEM_en,
  output logic                  IF_ID_flush,
  output logic                  ID_EX_flush,
  output logic                  EX_MEM_flush,
  output logic                  MEM_WB_bubble,
  output logic                  mem_timeout_err,
  output logic [1:0]            state_o
`ifdef PIPE_HAZARD_PERF_CNT_EN
  , output logic [CNT_W-1:0]    stall_cycles,
  output logic [CNT_W-1:0]      flush_events
`endif
);
  localparam int CW = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_V = CW'(MEM_TIMEOUT);
  typedef enum logic [1:0] {RUN = 2'b00, MEM_WAIT = 2'b01, ERROR = 2'b10} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic load_use, mem_stall, freeze;
  assign load_use = MemRead_in_Ex && rd_in_Ex != '0 &&
                    ((rs1_used_ID && rs1_in_ID == rd_in_Ex) || (rs2_used_ID && rs2_in_ID == rd_in_Ex));
  assign mem_stall = mem_req && !mem_ack;
  assign freeze = (state_q == RUN && mem_stall) || (state_q == MEM_WAIT && !mem_ack);
  assign mem_timeout_err = state_q == ERROR;
  assign state_o = state_q;
  always_comb begin
    state_d = state_q;
    wait_cnt_d = wait_cnt_q;
    {PC_en, IF_ID_en, ID_EX_en, EX_MEM_en} = 4'hf;
    {IF_ID_flush, ID_EX_flush, EX_MEM_flush} = 3'b000;
    MEM_WB_bubble = 1'b0;
    if (state_q == ERROR) begin
      {PC_en, IF_ID_en, ID_EX_en, EX_MEM_en} = 4'h0;
      MEM_WB_bubble = 1'b1;
    end else if (freeze) begin
      {PC_en, IF_ID_en, ID_EX_en, EX_MEM_en} = 4'h0;
      MEM_WB_bubble = 1'b1;
      state_d = MEM_WAIT;
      if (state_q == RUN) wait_cnt_d = CW'(1);
      else begin
        wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + CW'(1);
        if (MEM_TIMEOUT != 0 && wait_cnt_q == TO_V) state_d = ERROR;
      end
    end else begin
      state_d = RUN;
      wait_cnt_d = '0;
      if (PCSrc_in_Mem) {IF_ID_flush, ID_EX_flush, EX_MEM_flush} = 3'b111;
      else if (load_use) begin
        {PC_en, IF_ID_en} = 2'b00;
        ID_EX_flush = 1'b1;
      end
    end
    // Reset overrides combinationally so outputs go safe the instant rst_n drops
    if (!rst_n) begin
      {PC_en, IF_ID_en, ID_EX_en, EX_MEM_en} = 4'h0;
      {IF_ID_flush, ID_EX_flush, EX_MEM_flush} = 3'b111;
      MEM_WB_bubble = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d, flush_events_q, flush_events_d;
  always_comb begin
    stall_cycles_d = (!PC_en && state_q != ERROR && stall_cycles_q != '1) ? stall_cycles_q + CNT_W'(1) : stall_cycles_q;
    flush_events_d = (EX_MEM_flush && flush_events_q != '1) ? flush_events_q + CNT_W'(1) : flush_events_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif
endmodule
